spart_rx_gen: RTL

Parametrised SPART receiver, the next generation of the fixed 8N1 `rx` used beside `tx` and `baud_rate_gen` in `top_level`. It oversamples the serial line using the baud-rate-generator enable, majority-votes each bit, and supports configurable data width, parity and stop bits. Received frames are buffered with their error flags in a small FIFO, which the bus side drains with `rd_rx`.

---
 rtl/spart_pkg.sv | 23 ++
 rtl/spart_rx_fifo.sv | 51 +++++
 rtl/spart_rx_gen.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/spart_pkg.sv
// Shared types and constants for the parametrised SPART receiver.
package spart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } rx_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/spart_rx_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO; head reads as zero when empty.
module spart_rx_fifo
    import spart_pkg::*;
#(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same cycle, so a full FIFO can still accept.
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/spart_rx_gen.sv
// Oversampling SPART receiver: majority-voted bits, optional parity, 1/2 stop bits, frame FIFO.
module spart_rx_gen
    import spart_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DEPTH      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              RxD,
    input  logic [1:0]        parity_cfg,
    input  logic              stop2,
    input  logic              rd_rx,
    output logic [DATA_W-1:0] RxD_data,
    output logic              RDA,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun
);

    localparam int unsigned TW = clog2(OVERSAMPLE);
    localparam int unsigned BW = clog2(DATA_W);
    localparam int unsigned M  = OVERSAMPLE / 2;
    localparam int unsigned FW = DATA_W + 2;

    rx_state_e         state, next_state;
    logic              rx_meta, rxs;
    logic [TW-1:0]     tcnt;
    logic [BW-1:0]     bitcnt;
    logic              s_a, s_b;
    logic [DATA_W-1:0] shreg;
    logic              fe, par;
    logic [1:0]        cfg_l;
    logic              stop2_l;

    logic              tick_mid_c, tick_end_c, vote_c, last_bit_c, last_stop_c, par_en_c;
    logic              par_bad_c, push_c, pop_c, drop_c, full_c, empty_c;
    logic [FW-1:0]     head_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= RxD;
            rxs     <= rx_meta;
        end
    end

    assign tick_mid_c  = en && (tcnt == TW'(M + 1));
    assign tick_end_c  = en && (tcnt == TW'(OVERSAMPLE - 1));
    assign vote_c      = (s_a & s_b) | (s_a & rxs) | (s_b & rxs);
    assign last_bit_c  = (bitcnt == BW'(DATA_W - 1));
    assign last_stop_c = stop2_l ? (bitcnt == BW'(1)) : 1'b1;
    assign par_en_c    = (cfg_l == PAR_EVEN) || (cfg_l == PAR_ODD);
    assign par_bad_c   = (^{shreg, vote_c}) ^ (cfg_l == PAR_ODD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        push_c     = 1'b0;
        case (state)
            S_IDLE:   if (en && !rxs) next_state = S_START;
            S_START: begin
                if (tick_mid_c && vote_c) next_state = S_IDLE;
                else if (tick_end_c)      next_state = S_DATA;
            end
            S_DATA:   if (tick_end_c && last_bit_c) next_state = par_en_c ? S_PARITY : S_STOP;
            S_PARITY: if (tick_end_c) next_state = S_STOP;
            // Leave at the final mid-sample so the next start edge is caught early.
            S_STOP: begin
                if (tick_mid_c && last_stop_c) begin
                    next_state = S_IDLE;
                    push_c     = 1'b1;
                end
            end
            default:  next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt    <= '0;
            bitcnt  <= '0;
            s_a     <= 1'b1;
            s_b     <= 1'b1;
            shreg   <= '0;
            fe      <= 1'b0;
            par     <= 1'b0;
            cfg_l   <= PAR_NONE;
            stop2_l <= 1'b0;
        end else if (state == S_IDLE) begin
            if (en && !rxs) begin
                tcnt    <= '0;
                bitcnt  <= '0;
                fe      <= 1'b0;
                par     <= 1'b0;
                cfg_l   <= parity_cfg;
                stop2_l <= stop2;
            end
        end else if (en) begin
            tcnt <= tick_end_c ? '0 : tcnt + TW'(1);
            if (tcnt == TW'(M - 1)) s_a <= rxs;
            if (tcnt == TW'(M))     s_b <= rxs;
            if (tick_mid_c) begin
                case (state)
                    S_DATA:   shreg <= {vote_c, shreg[DATA_W-1:1]};
                    S_PARITY: par   <= par_bad_c;
                    S_STOP:   if (!vote_c) fe <= 1'b1;
                    default:  ;
                endcase
            end
            if (tick_end_c) begin
                case (state)
                    S_DATA:   bitcnt <= last_bit_c ? '0 : bitcnt + BW'(1);
                    S_STOP:   bitcnt <= bitcnt + BW'(1);
                    default:  bitcnt <= '0;
                endcase
            end
        end
    end

    assign pop_c  = rd_rx && !empty_c;
    assign drop_c = push_c && full_c && !pop_c;

    spart_rx_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (push_c),
        .pop   (pop_c),
        .wdata ({fe | ~vote_c, par, shreg}),
        .rdata (head_c),
        .full  (full_c),
        .empty (empty_c)
    );

    // Sticky drop flag; a drop in the same cycle as a read wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        overrun <= 1'b0;
        else if (drop_c) overrun <= 1'b1;
        else if (pop_c)  overrun <= 1'b0;
    end

    assign RxD_data   = head_c[DATA_W-1:0];
    assign parity_err = head_c[DATA_W];
    assign frame_err  = head_c[DATA_W+1];
    assign RDA        = !empty_c;

endmodule
